// File: rtl/mips_pkg.sv
//------------------------------------------------------------------------------
// Module : mips_pkg
// Brief  : Shared opcodes, controller state encodings and decode helpers.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package mips_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_RR   = 3'b010,
        S_EX   = 3'b011,
        S_RWB  = 3'b100,
        S_HLT  = 3'b101,
        S_IDLE = 3'b111
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_CMPJ = 4'hD;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Control-flow and no-op instructions never commit RD.
    function automatic logic writes_rf(input logic [3:0] op);
        return !(op inside {OP_JMP, OP_CMPJ, OP_HALT, OP_NOP});
    endfunction

endpackage

`default_nettype wire

// File: rtl/mips_pc_next.sv
//------------------------------------------------------------------------------
// Module : mips_pc_next
// Brief  : Combinational next-PC select: jump target, compare-branch, or PC+1.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_pc_next
    import mips_pkg::*;
#(
    parameter int PC_W = 8
) (
    input  logic [PC_W-1:0] pc,
    input  logic [3:0]      opcode,
    input  logic [11:0]     field,
    input  logic            cmp_eq,
    output logic [PC_W-1:0] pc_next
);

    logic [PC_W-1:0] offset;
    logic [PC_W-1:0] jmp_target;

    always_comb begin
        offset     = {{(PC_W-4){field[11]}}, field[11:8]};
        jmp_target = PC_W'(field[7:0]);
        pc_next    = pc + PC_W'(1);
        if (opcode == OP_JMP) begin
            pc_next = jmp_target;
        end else if (opcode == OP_CMPJ && cmp_eq) begin
            pc_next = pc + offset;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mips_ctrl_fsm.sv
//------------------------------------------------------------------------------
// Module : mips_ctrl_fsm
// Brief  : Multi-cycle MIPS-style control FSM (IF/ID/RR/EX/RWB/HLT) with PC.
//          Optional retired-instruction counter under MIPS_CTRL_PERF_CNT_EN.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mips_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic            instr_req,
    output logic [PC_W-1:0] instr_addr,
    input  logic            instr_valid,
    input  logic [15:0]     instr_data,
    input  logic [7:0]      RF_data_out0,
    input  logic [7:0]      RF_data_out1,
    output logic [3:0]      OPCODE,
    output logic [3:0]      RA,
    output logic [3:0]      RB,
    output logic [3:0]      RD,
    output logic [2:0]      current_state,
    output logic            rf_we,
    output logic            halted
`ifdef MIPS_CTRL_PERF_CNT_EN
    ,
    output logic [15:0]     retired_cnt
`endif
);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_next;
    logic [15:0]     ir;
    logic            cmp_eq;

    assign instr_addr    = pc;
    assign OPCODE        = ir[15:12];
    assign RD            = ir[11:8];
    assign RA            = ir[7:4];
    assign RB            = ir[3:0];
    assign current_state = state;

    mips_pc_next #(
        .PC_W    (PC_W)
    ) u_pc_next (
        .pc      (pc),
        .opcode  (ir[15:12]),
        .field   (ir[11:0]),
        .cmp_eq  (cmp_eq),
        .pc_next (pc_next)
    );

    // Outputs are registered alongside the state so they reflect the state entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= 16'h0000;
            cmp_eq    <= 1'b0;
            instr_req <= 1'b0;
            rf_we     <= 1'b0;
            halted    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_IF;
                        instr_req <= 1'b1;
                    end
                end
                S_IF: begin
                    if (instr_valid) begin
                        ir        <= instr_data;
                        state     <= S_ID;
                        instr_req <= 1'b0;
                    end
                end
                S_ID: state <= S_RR;
                S_RR: state <= S_EX;
                S_EX: begin
                    cmp_eq <= (RF_data_out0 == RF_data_out1);
                    if (ir[15:12] == OP_HALT) begin
                        state  <= S_HLT;
                        halted <= 1'b1;
                    end else begin
                        state  <= S_RWB;
                        rf_we  <= writes_rf(ir[15:12]);
                    end
                end
                S_RWB: begin
                    state     <= S_IF;
                    pc        <= pc_next;
                    rf_we     <= 1'b0;
                    instr_req <= 1'b1;
                end
                S_HLT: state <= S_HLT;
                default: begin
                    state     <= S_IDLE;
                    instr_req <= 1'b0;
                    rf_we     <= 1'b0;
                end
            endcase
        end
    end

`ifdef MIPS_CTRL_PERF_CNT_EN
    logic retire;

    assign retire = (state == S_RWB) || (state == S_EX && ir[15:12] == OP_HALT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            retired_cnt <= 16'h0000;
        end else if (retire && retired_cnt != 16'hFFFF) begin
            retired_cnt <= retired_cnt + 16'h0001;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_ctrl_fsm.sv
//------------------------------------------------------------------------------
// Module : tb_mips_ctrl_fsm
// Brief  : Directed scoreboard bench for mips_ctrl_fsm.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mips_ctrl_fsm;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        instr_valid = 1'b0;
    logic [15:0] instr_data = 16'h0000;
    logic [7:0]  rf0 = 8'h00;
    logic [7:0]  rf1 = 8'h00;
    logic        instr_req;
    logic [7:0]  instr_addr;
    logic [3:0]  OPCODE, RA, RB, RD;
    logic [2:0]  current_state;
    logic        rf_we;
    logic        halted;
`ifdef MIPS_CTRL_PERF_CNT_EN
    logic [15:0] retired_cnt;
`endif

    mips_ctrl_fsm #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .instr_req     (instr_req),
        .instr_addr    (instr_addr),
        .instr_valid   (instr_valid),
        .instr_data    (instr_data),
        .RF_data_out0  (rf0),
        .RF_data_out1  (rf1),
        .OPCODE        (OPCODE),
        .RA            (RA),
        .RB            (RB),
        .RD            (RD),
        .current_state (current_state),
        .rf_we         (rf_we),
        .halted        (halted)
`ifdef MIPS_CTRL_PERF_CNT_EN
        ,
        .retired_cnt   (retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [7:0] fetch_pc;
        logic [3:0] ra, rb, rd;
        int         we_cycles;
        logic [7:0] next_pc;
        int         latency;
        bit         halts;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input string tag, input logic [7:0] fpc, input logic [15:0] word,
                                input int we, input logic [7:0] npc, input bit h);
        exp_t e;
        e.tag = tag; e.fetch_pc = fpc;
        e.rd = word[11:8]; e.ra = word[7:4]; e.rb = word[3:0];
        e.we_cycles = we; e.next_pc = npc; e.halts = h;
        e.latency = h ? 4 : 5;
        return e;
    endfunction

    task automatic wait_req(input string tag);
        for (int i = 0; i < 50 && !instr_req; i++) @(negedge clk);
        check({tag, "/req_seen"}, 32'(instr_req), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_instr(input exp_t e, input logic [15:0] word, input int delay,
                             input logic [7:0] d0, input logic [7:0] d1);
        exp_t got;
        int   we_cnt = 0;
        int   lat = 1;
        bit   done = 1'b0;
        sb.push_back(e);
        wait_req(e.tag);
        check({e.tag, "/fetch_addr"}, 32'(instr_addr), 32'(e.fetch_pc));
        instr_data = 16'hF0F0;
        repeat (delay) @(negedge clk);
        instr_valid = 1'b1; instr_data = word; rf0 = d0; rf1 = d1;
        @(negedge clk);
        instr_valid = 1'b0; instr_data = 16'hFFFF;
        while (!done && lat < 20) begin
            if (rf_we) we_cnt++;
            if (instr_req || halted) done = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        got = sb.pop_front();
        check({got.tag, "/no_timeout"}, 32'(done), 32'd1);
        check({got.tag, "/RA"}, 32'(RA), 32'(got.ra));
        check({got.tag, "/RB"}, 32'(RB), 32'(got.rb));
        check({got.tag, "/RD"}, 32'(RD), 32'(got.rd));
        check({got.tag, "/rf_we_cycles"}, 32'(we_cnt), 32'(got.we_cycles));
        check({got.tag, "/latency"}, 32'(lat), 32'(got.latency));
        check({got.tag, "/halted"}, 32'(halted), 32'(got.halts));
        if (!got.halts) check({got.tag, "/next_addr"}, 32'(instr_addr), 32'(got.next_pc));
    endtask

    logic [15:0] w;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst/state", 32'(current_state), 32'(3'b111));
        check("rst/pc", 32'(instr_addr), 32'h00);
        check("rst/opcode", 32'(OPCODE), 32'(OP_NOP));
        check("rst/regs", {20'd0, RA, RB, RD}, 32'd0);
        check("rst/outs", {29'd0, instr_req, rf_we, halted}, 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_hold", 32'(current_state), 32'(3'b111));
        pulse_start();

        w = {OP_ADD, 12'h312};
        run_instr(mk("add0", 8'h00, w, 1, 8'h01, 0), w, 3, 8'h11, 8'h22);
        w = {OP_JMP, 12'h040};
        run_instr(mk("jmp40", 8'h01, w, 0, 8'h40, 0), w, 0, 8'h00, 8'h00);
        w = {OP_JMP, 12'h002};
        run_instr(mk("jmp02", 8'h40, w, 0, 8'h02, 0), w, 1, 8'h00, 8'h00);
        w = {OP_CMPJ, 12'hD12};
        run_instr(mk("cmpj_eq", 8'h02, w, 0, 8'hFF, 0), w, 0, 8'h55, 8'h55);
        w = {OP_ADD, 12'h756};
        run_instr(mk("add_wrap", 8'hFF, w, 1, 8'h00, 0), w, 2, 8'h01, 8'h02);
        w = {OP_JMP, 12'h002};
        run_instr(mk("jmp02b", 8'h00, w, 0, 8'h02, 0), w, 0, 8'h00, 8'h00);
        w = {OP_CMPJ, 12'hD12};
        run_instr(mk("cmpj_ne", 8'h02, w, 0, 8'h03, 0), w, 0, 8'h55, 8'h56);

        // Reset while a fetch at PC 3 has valid data pending
        wait_req("mid_if");
        instr_data = {OP_ADD, 12'h9AB};
        instr_valid = 1'b1;
        reset_n = 1'b0;
        #1;
        check("mid_if/state", 32'(current_state), 32'(3'b111));
        check("mid_if/pc", 32'(instr_addr), 32'h00);
        check("mid_if/opcode", 32'(OPCODE), 32'(OP_NOP));
        check("mid_if/req", 32'(instr_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("mid_if/rf_we", 32'(rf_we), 32'd0);
        end
        instr_valid = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        pulse_start();

        w = {OP_SUB, 12'h123};
        run_instr(mk("sub", 8'h00, w, 1, 8'h01, 0), w, 0, 8'h01, 8'h02);
        w = {OP_AND, 12'h456};
        run_instr(mk("and", 8'h01, w, 1, 8'h02, 0), w, 1, 8'h03, 8'h04);
        w = {OP_OR, 12'h789};
        run_instr(mk("or", 8'h02, w, 1, 8'h03, 0), w, 0, 8'h05, 8'h06);
        w = {OP_HALT, 12'h000};
        run_instr(mk("halt", 8'h03, w, 0, 8'h03, 1), w, 0, 8'h00, 8'h00);

        check("hlt/state", 32'(current_state), 32'(3'b101));
        check("hlt/req", 32'(instr_req), 32'd0);
        pulse_start();
        repeat (3) @(negedge clk);
        check("hlt/start_ignored", 32'(current_state), 32'(3'b101));
        check("hlt/req_after_start", 32'(instr_req), 32'd0);
        check("hlt/rf_we", 32'(rf_we), 32'd0);
        check("hlt/pc", 32'(instr_addr), 32'h03);
`ifdef MIPS_CTRL_PERF_CNT_EN
        check("perf/retired", 32'(retired_cnt), 32'd4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/mips_ctrl_fsm.md
MIPS_CTRL_FSM -- requirements
Module: mips_ctrl_fsm

Interface
REQ-001 Parameter PC_W, default 8, width of the instruction address / program counter.
REQ-002 Parameter RESET_PC, default 8'h00, PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; leaves IDLE and begins fetching at PC.
REQ-006 instr_req  output  1  fetch request, held high while in IF.
REQ-007 instr_addr  output  PC_W  fetch address; equals PC.
REQ-008 instr_valid  input  1  instr_data valid this cycle; sampled only while instr_req=1.
REQ-009 instr_data  input  16  instruction word: [15:12] opcode, [11:8] RD, [7:4] RA, [3:0] RB.
REQ-010 RF_data_out0 / RF_data_out1  input  8 each  registered register-file read data for RA / RB.
REQ-011 OPCODE  output  4  opcode of the current instruction.
REQ-012 RA, RB, RD  output  4 each  register-file read/write addresses.
REQ-013 current_state  output  3  state encoding, drives the register-file write qualifier.
REQ-014 rf_we  output  1  high exactly when the register file commits RD.
REQ-015 halted  output  1  high in HLT.

Function
REQ-016 States and encodings: IF=000, ID=001, RR=010, EX=011, RWB=100, HLT=101, IDLE=111.
REQ-017 Transitions:
- IDLE->IF on start.
- IF->ID on instr_valid, capturing instr_data into the instruction register; IF holds without limit while instr_valid=0.
- ID->RR->EX->RWB unconditionally, one cycle each.
- RWB->IF.
- EX->HLT when OPCODE==HALT; HLT is held until reset.
REQ-018 OPCODE/RA/RB/RD update only on the IF->ID edge and stay stable through RWB, so RF_data_out0/1 are valid during RR and EX.
REQ-019 rf_we = (current_state==RWB) and OPCODE not in {JMP, CMPJ, HALT, NOP}.
REQ-020 PC update, on leaving RWB only:
- JMP: PC <= instr[7:0].
- CMPJ with RF_data_out0==RF_data_out1 (sampled in EX): PC <= PC + sign-extended instr[11:8].
- All others: PC <= PC+1.
REQ-021 PC arithmetic is modulo 2^PC_W; wrap-around (8'hFF+1 -> 8'h00, 8'h02-3 -> 8'hFF) is legal and silent.
REQ-022 start outside IDLE is ignored; instr_valid outside IF is ignored.
REQ-023 A fetch in flight when reset_n asserts is abandoned; no instruction is captured and rf_we stays 0.
REQ-024 Latency: 5 cycles from instr_valid to the next instr_req for non-halting instructions with zero fetch wait.

Reset
REQ-025 While reset_n=0, asynchronously:
- state=IDLE, PC=RESET_PC, instruction register=16'h0000 (OPCODE=NOP).
- RA=RB=RD=0.
- instr_req=0, rf_we=0, halted=0.
REQ-026 First transition occurs on the first rising clk edge after reset_n deasserts.

Configuration
REQ-027 Macro MIPS_CTRL_PERF_CNT_EN.
- Defined: adds output retired_cnt (16 bits), reset to 0, incremented on every RWB->IF or EX->HLT transition, saturating at 16'hFFFF.
- Undefined: no port and no counter logic.

Structure
REQ-028 The opcode constants (JMP, CMPJ, HALT, NOP, ALU ops) and the state encodings belong in shared package mips_pkg, which the register file and ALU also use.
REQ-029 A single sub-module, mips_pc_next (combinational next-PC select and adder), is instantiated once; all other logic is flat.

Verification
REQ-030 Reset mid-IF with instr_valid pending -> state=IDLE, PC=RESET_PC, rf_we never high.
REQ-031 start, then fetch of 16'h<ADD>312 at PC 0 after a 3-cycle valid delay -> RA=1, RB=2, RD=3; rf_we=1 for exactly one cycle in RWB; next instr_addr=1.
REQ-032 JMP instr[7:0]=8'h40 -> rf_we stays 0, next instr_addr=8'h40.
REQ-033 CMPJ at PC 8'h02 with offset 4'hD and RF_data_out0=RF_data_out1=8'h55 -> next PC 8'hFF; with 8'h55 vs 8'h56 -> next PC 8'h03.
REQ-034 HALT -> halted=1 from the cycle after EX, instr_req stays 0, start ignored until reset.
REQ-035 With MIPS_CTRL_PERF_CNT_EN, 3 ALU instructions then HALT -> retired_cnt=4.
